alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-requester controller that shares the single 64-bit combinational ALU (add/sub/and/xor units with overflow flag) in the execute datapath. It arbitrates round-robin between requesters and sequences each accepted operation through a registered compute stage. It returns the result and overflow flag on one tagged response channel, and maintains the architectural condition-code register (ZF, SF, OF).

## Interface
- WIDTH, 64, operand/result width in bits
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_fn / req1_fn  in  2  function: 0 add, 1 sub (a−b), 2 and, 3 xor
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  signed operands
- req0_setcc  in  1  requester 0 only: update CC with this result
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the op
- rsp_result  out  WIDTH  ALU result
- rsp_of  out  1  signed overflow of this op
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the single valid requester; if both are valid, to the requester pointed at by rr_ptr.
  - The granted reqN_ready is asserted combinationally in IDLE only.
  - On accept: latch fn, a, b, id, and setcc (forced 0 for id 1), then go to EXEC.
- EXEC:
  - Drive latched operands into the ALU.
  - Register result and OF into the response registers.
  - If setcc: cc_zf ← (result==0), cc_sf ← result[WIDTH−1], cc_of ← OF, on the same edge.
  - Then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result, and rsp_of stay stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE and set rr_ptr ← ~rsp_id.
- Arithmetic: wrap modulo 2^WIDTH.
  - add: OF = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - sub (r = a−b): OF = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - and, xor: OF = 0.
- Both ready outputs are low outside IDLE. No request is ever dropped once ready has been seen.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_of=0, cc_zf=1, cc_sf=0, cc_of=0, req0_ready/req1_ready follow IDLE grant rules.
- rst asserted in EXEC or RESP abandons the transaction: no response, no CC update from it.

## Timing
- Accept at edge N (valid&&ready) → rsp_valid high from cycle N+2.
- CC is visible from cycle N+2, coincident with rsp_valid.
- Minimum spacing: 3 cycles per op with rsp_ready tied high. The next accept happens in the cycle after the response handshake.
- Backpressure: rsp_ready low holds RESP indefinitely; requests wait with ready low.
- rr_ptr changes only on the response handshake. Under continuous dual requests, grants strictly alternate 0,1,0,1.
- Simultaneous rst and handshake: rst wins.

## Structure
- Package alu_ctrl_pkg: WIDTH default, fn_e enum (FN_ADD=0, FN_SUB=1, FN_AND=2, FN_XOR=3), state_e enum (IDLE, EXEC, RESP).
- Sub-module alu64:
  - Purely combinational; inputs fn, a, b; outputs result and of.
  - Instantiates the existing 64-bit add/sub/and/xor units and muxes by fn.
- Top alu_share_ctrl: arbiter, FSM, operand/response/CC registers.

## Test plan
- Reset → rsp_valid=0, cc_zf=1, cc_sf=0, cc_of=0; a req1 presented during rst is not accepted.
- req0 and, a=0x26, b=0x31, setcc=1, rsp_ready=1 → rsp_valid 2 cycles later; result=0x20, of=0, id=0; CC zf=0 sf=0 of=0.
- req0 add, a=0x7FFF_FFFF_FFFF_FFFF, b=1, setcc=1 → result=0x8000_0000_0000_0000, of=1; CC sf=1 of=1 zf=0.
- req1 sub, a=5, b=5 → result=0, id=1, of=0; CC unchanged.
- Both valid continuously (req0 xor, a=b=−0x21; req1 and, a=−0x2D, b=0x15):
  - Grants alternate 0,1,0,1 starting with 0.
  - Req0 xor result=0.
  - Req1 and result=0x11, since −0x2D=…D3 and 0xD3&0x15=0x11.
- rsp_ready low for 5 cycles in RESP → rsp fields stable and both readys low. Asserting rst while in EXEC gives no response and leaves CC at its previous value.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the shared-ALU controller.
package alu_ctrl_pkg;

  localparam int WIDTH = 64;

  typedef enum logic [1:0] {
    FN_ADD = 2'd0,
    FN_SUB = 2'd1,
    FN_AND = 2'd2,
    FN_XOR = 2'd3
  } fn_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // One accepted operation as held in the operand registers.
  typedef struct packed {
    fn_e              fn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             id;
    logic             setcc;
  } op_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response/condition-code bundle between the requesters and the
// shared-ALU controller. The controller uses the slave side.
interface alu_share_ctrl_if;
  import alu_ctrl_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  fn_e              req0_fn;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_setcc;

  logic             req1_valid;
  logic             req1_ready;
  fn_e              req1_fn;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_of;

  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;

  modport master (
    output req0_valid, req0_fn, req0_a, req0_b, req0_setcc,
    output req1_valid, req1_fn, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_of,
    input  cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  req0_valid, req0_fn, req0_a, req0_b, req0_setcc,
    input  req1_valid, req1_fn, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_of,
    output cc_zf, cc_sf, cc_of
  );

endinterface

// File: rtl/alu_share_ctrl_alu64.sv
// Combinational 64-bit ALU: add/sub/and/xor units muxed by function code,
// with signed-overflow detection for add and sub.
module alu64
  import alu_ctrl_pkg::*;
(
  input  fn_e              fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             of
);

  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] xor_r;
  logic             add_of;
  logic             sub_of;

  // Function units, all wrapping modulo 2^WIDTH.
  assign add_r = a + b;
  assign sub_r = a - b;
  assign and_r = a & b;
  assign xor_r = a ^ b;

  // Signed overflow: result sign disagrees with what the operand signs allow.
  assign add_of = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
  assign sub_of = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);

  // Select the unit output for the requested function.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    result = add_r;
    of     = 1'b0;
    unique case (fn)
      FN_ADD: begin result = add_r; of = add_of; end
      FN_SUB: begin result = sub_r; of = sub_of; end
      FN_AND: result = and_r;
      FN_XOR: result = xor_r;
      default: begin result = add_r; of = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-requester controller for the shared execute ALU: round-robin arbiter,
// IDLE/EXEC/RESP sequencer, operand/response registers and the ZF/SF/OF
// condition-code register (only requester 0 may update it).
module alu_share_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_share_ctrl_if.slave   bus
);

  state_e           state_q;
  state_e           state_d;
  logic             rr_ptr_q;
  logic             gnt_id;
  logic             any_valid;
  logic             accept;
  logic             ready0;
  logic             ready1;
  logic             rsp_done;

  op_t              op_q;
  op_t              op_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_of;

  logic [WIDTH-1:0] result_q;
  logic             of_q;
  logic             id_q;
  logic             zf_q;
  logic             sf_q;
  logic             ccof_q;

  // Grant: the lone valid requester, or rr_ptr when both are asking.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) gnt_id = rr_ptr_q;
    else                                  gnt_id = bus.req1_valid;
  end

  // Operand bundle of the granted requester; requester 1 never touches CC.
  always_comb begin
    op_d.fn    = bus.req0_fn;
    op_d.a     = bus.req0_a;
    op_d.b     = bus.req0_b;
    op_d.id    = 1'b0;
    op_d.setcc = bus.req0_setcc;
    if (gnt_id) begin
      op_d.fn    = bus.req1_fn;
      op_d.a     = bus.req1_a;
      op_d.b     = bus.req1_b;
      op_d.id    = 1'b1;
      op_d.setcc = 1'b0;
    end
  end

  // Next-state and handshake outputs; readys only ever rise in IDLE.
  always_comb begin
    state_d = state_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          accept  = 1'b1;
          ready0  = ~gnt_id;
          ready1  = gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_done = (state_q == RESP) && bus.rsp_ready;

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture on accept.
  always_ff @(posedge clk) begin
    // NOTE: datapath operand registers carry no reset; they are only read in EXEC after a fresh accept.
    if (accept) op_q <= op_d;
  end

  alu64 u_alu (
    .fn     (op_q.fn),
    .a      (op_q.a),
    .b      (op_q.b),
    .result (alu_result),
    .of     (alu_of)
  );

  // Response and condition-code registers, written from the ALU in EXEC;
  // the round-robin pointer moves only on the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      result_q <= '0;
      of_q     <= 1'b0;
      id_q     <= 1'b0;
      zf_q     <= 1'b1;
      sf_q     <= 1'b0;
      ccof_q   <= 1'b0;
    end else begin
      if (state_q == EXEC) begin
        result_q <= alu_result;
        of_q     <= alu_of;
        id_q     <= op_q.id;
        if (op_q.setcc) begin
          zf_q   <= (alu_result == '0);
          sf_q   <= alu_result[WIDTH-1];
          ccof_q <= alu_of;
        end
      end
      if (rsp_done) rr_ptr_q <= ~id_q;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_of     = of_q;
  assign bus.cc_zf      = zf_q;
  assign bus.cc_sf      = sf_q;
  assign bus.cc_of      = ccof_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl. Inputs change on the
// falling edge, outputs are sampled on the falling edge (or just after it).
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_ctrl_if bus ();

  alu_share_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present one request at a falling edge and wait (bounded) for its accept.
  // Returns at the falling edge after the accepting rising edge (DUT in EXEC).
  task automatic issue(input logic id, input fn_e fn, input logic [63:0] a,
                       input logic [63:0] b, input logic setcc);
    bit ok = 1'b0;
    if (id) begin
      bus.req1_fn = fn; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_fn = fn; bus.req0_a = a; bus.req0_b = b;
      bus.req0_setcc = setcc; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", ok, 1'b1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_setcc = 1'b0;
  endtask

  // Called in EXEC: response must appear exactly one cycle later, with CC.
  task automatic expect_rsp(input string tag, input logic id, input logic [63:0] res,
                            input logic of, input logic zf, input logic sf, input logic cof);
    check({tag, "_exec_novalid"}, bus.rsp_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"},  bus.rsp_valid,  1'b1);
    check({tag, "_id"},     bus.rsp_id,     id);
    check({tag, "_result"}, bus.rsp_result, res);
    check({tag, "_of"},     bus.rsp_of,     of);
    check({tag, "_cc"},     {bus.cc_zf, bus.cc_sf, bus.cc_of}, {zf, sf, cof});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ids   [4];
    logic [63:0] rsl   [4];
    int          cyc   [4];
    int          seen;

    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_fn = FN_ADD; bus.req0_a = '0; bus.req0_b = '0;
    bus.req0_setcc = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_fn = FN_SUB; bus.req1_a = 64'd9; bus.req1_b = 64'd4;
    bus.rsp_ready  = 1'b1;

    // Reset state, with req1 knocking during reset.
    repeat (3) @(negedge clk);
    check("rst_rsp_valid",  bus.rsp_valid,  1'b0);
    check("rst_rsp_id",     bus.rsp_id,     1'b0);
    check("rst_rsp_result", bus.rsp_result, 64'd0);
    check("rst_cc",         {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b100);
    rst = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", bus.rsp_valid, 1'b0);
    end

    // req0 and with CC update.
    issue(1'b0, FN_AND, 64'h26, 64'h31, 1'b1);
    expect_rsp("and", 1'b0, 64'h20, 1'b0, 1'b0, 1'b0, 1'b0);

    // req0 add with signed overflow.
    issue(1'b0, FN_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    expect_rsp("add_of", 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Backpressure: -3 + 1 = -2, held 5 cycles while req1 waits.
    bus.rsp_ready = 1'b0;
    issue(1'b0, FN_ADD, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b1);
    bus.req1_fn = FN_SUB; bus.req1_a = 64'd5; bus.req1_b = 64'd5; bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_valid",  bus.rsp_valid,  1'b1);
      check("bp_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("bp_id",     bus.rsp_id,     1'b0);
      check("bp_ready",  {bus.req0_ready, bus.req1_ready}, 2'b00);
    end
    check("bp_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b010);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);

    // req1 sub: result 0 but CC must not move.
    issue(1'b1, FN_SUB, 64'd5, 64'd5, 1'b0);
    expect_rsp("sub1", 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Both requesting continuously: alternate 0,1,0,1, one op per 3 cycles.
    bus.req0_fn = FN_XOR; bus.req0_a = 64'hFFFF_FFFF_FFFF_FFDF;
    bus.req0_b = 64'hFFFF_FFFF_FFFF_FFDF; bus.req0_setcc = 1'b1; bus.req0_valid = 1'b1;
    bus.req1_fn = FN_AND; bus.req1_a = 64'hFFFF_FFFF_FFFF_FFD3;
    bus.req1_b = 64'h15; bus.req1_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && seen < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        ids[seen] = bus.rsp_id;
        rsl[seen] = bus.rsp_result;
        cyc[seen] = c;
        seen++;
        if (seen == 4) begin
          bus.req0_valid = 1'b0;
          bus.req1_valid = 1'b0;
          bus.req0_setcc = 1'b0;
        end
      end
    end
    check("dual_count", seen, 4);
    for (int i = 0; i < seen; i++) begin
      check("dual_id",     ids[i], i % 2);
      check("dual_result", rsl[i], (i % 2 == 0) ? 64'd0 : 64'h11);
      if (i > 0) check("dual_spacing", cyc[i] - cyc[i-1], 3);
    end
    @(negedge clk);
    check("dual_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b100);

    // Reset during EXEC abandons an op that would have set SF/OF.
    issue(1'b0, FN_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", bus.rsp_valid, 1'b0);
    end
    check("abort_cc",     {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b100);
    check("abort_result", bus.rsp_result, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
